fx_mul_pipe: RTL
================

# fx_mul_pipe

Multi-lane pipelined signed fixed-point multiplier with a valid/ready handshake, selectable rounding and optional saturation. It replaces the start/done multiplier in the math datapath (LSM regression and path-update arithmetic), where downstream consumers can stall. It sustains one product per lane per cycle, preserves order under backpressure, and reports overflow per lane and as a sticky flag.

## Interface
- WIDTH, 32: total signed operand/result width, ≥ 4.
- QINT, 16: integer bits including sign; QFRAC = WIDTH − QINT, must be ≥ 1.
- LANES, 1: parallel independent multiply lanes sharing one handshake.
- LATENCY, 2: pipeline depth in cycles, ≥ 2.
- ROUND, 0: 0 = truncate (floor toward −∞), 1 = round half up (add 2^(QFRAC−1) before shift).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block accepts the bundle this cycle.
- a  in  LANES*WIDTH  packed signed Q operands; lane i at [i*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  packed signed Q operands.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts the result.
- result  out  LANES*WIDTH  packed signed Q products.
- ovf  out  LANES  per-lane overflow of the current result, qualified by out_valid.
- ovf_sticky  out  1  set by any lane overflow on an output handshake.
- ovf_clr  in  1  synchronous clear of ovf_sticky.

## Operation
- Handshake fires when valid && ready on the same edge; data/valid must hold while valid && !ready.
- Stage 1 registers full 2*WIDTH signed products per lane; stages 2..LATENCY−1 are delay; stage LATENCY rounds, shifts right arithmetically by QFRAC, and saturates/wraps into the output registers.
- Each stage carries a valid bit. Global advance = !out_valid || out_ready; all stages shift on advance, otherwise all hold. in_ready = advance (combinational from out_ready and out_valid).
- Bubbles are not compacted: a stalled pipeline holds bubbles too.
- Arithmetic: r = (p + (ROUND ? 2^(QFRAC−1) : 0)) >>> QFRAC, computed in 2*WIDTH+1 bits so rounding cannot overflow. Overflow when r lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- ovf_sticky: set on any output handshake with nonzero ovf; ovf_clr in the same cycle as a set wins the clear (set takes priority).
- Reset: all stage valids, out_valid, result, ovf, ovf_sticky → 0. Reset mid-operation discards in-flight data; in_ready reads 1 after reset releases.

## Timing
- Latency: bundle accepted on edge N appears with out_valid high after edge N+LATENCY−1 (visible in cycle N+LATENCY), given out_ready high throughout.
- Throughput: one bundle per cycle with out_ready held high.
- Capacity: LATENCY bundles in flight; with out_ready low, in_ready falls once out_valid is high.
- result and ovf stay stable while out_valid && !out_ready.

## Configuration
- FX_MUL_SAT_EN defined: overflowing lanes clamp to 2^(WIDTH−1)−1 or −2^(WIDTH−1) by sign of r; ovf set.
- Undefined: result is r[WIDTH−1:0] (two's-complement wrap); ovf is still computed and reported, and ovf_sticky still operates.

## Structure
- Package fx_pkg: round mode localparams (FX_RND_TRUNC, FX_RND_HALF_UP), Q-format max/min helper functions, fx_mul_pipe width constants.
- Sub-module fx_round_sat: combinational per-lane round/shift/saturate (2*WIDTH in, WIDTH out plus ovf), instanced LANES times in the final stage.

## Test plan
- WIDTH=32, QINT=16, ROUND=0: a=0x00018000 (1.5), b=0x00020000 (2.0) → result 0x00030000, ovf=0, exactly 2 cycles after accept.
- SAT_EN defined: 200.0×300.0 → 0x7FFFFFFF, ovf=1, ovf_sticky=1; −200.0×300.0 → 0x80000000. SAT_EN undefined: 200.0×300.0 → 0xEA600000 (wrap), ovf=1.
- Rounding: a=0x00000001, b=0x00008000 → 0x00000000 (ROUND=0), 0x00000001 (ROUND=1); a=0xFFFFFFFF, b=0x00008000 → 0xFFFFFFFF (ROUND=0), 0x00000000 (ROUND=1).
- Backpressure, LANES=4: stream 8 bundles while out_ready toggles 0/1 randomly and holds low for 5 cycles → all 8 outputs in order, no loss/duplication, in_ready low while stalled and out_valid high.
- ovf_sticky: assert ovf_clr with no overflow → clears to 0; overflowing handshake coincident with ovf_clr → stays 1.
- Reset asserted with 2 bundles in flight → out_valid, result, ovf, ovf_sticky all 0 asynchronously; after release the first new bundle emerges with correct latency and no stale outputs.

Source files
------------

// File: rtl/fx_pkg.sv
// ---------------------------------------------------------------------------
// fx_pkg
// Shared constants and helpers for the pipelined fixed-point multiplier.
//   - rounding mode codes (FX_RND_TRUNC, FX_RND_HALF_UP)
//   - default geometry for fx_mul_pipe
//   - Q-format largest / smallest representable value helpers
// ---------------------------------------------------------------------------
package fx_pkg;

    localparam int FX_RND_TRUNC   = 0;   // floor toward -inf
    localparam int FX_RND_HALF_UP = 1;   // add half an LSB, then floor

    localparam int FX_DEF_WIDTH   = 32;
    localparam int FX_DEF_QINT    = 16;
    localparam int FX_DEF_LANES   = 1;
    localparam int FX_DEF_LATENCY = 2;

    // Helper results are this wide; callers slice off their own WIDTH.
    localparam int FX_MAX_W = 128;

    // 2^(width-1)-1, zero-extended to FX_MAX_W.
    function automatic logic [FX_MAX_W-1:0] fx_q_max(input int width);
        return (FX_MAX_W'(1) << (width - 1)) - FX_MAX_W'(1);
    endfunction

    // -2^(width-1), sign-extended to FX_MAX_W.
    function automatic logic [FX_MAX_W-1:0] fx_q_min(input int width);
        return ~fx_q_max(width);
    endfunction

endpackage

// File: rtl/fx_mul_pipe_if.sv
// ---------------------------------------------------------------------------
// fx_mul_pipe_if
// Valid/ready operand and result channels of fx_mul_pipe plus overflow
// status. master = producer/consumer side, slave = the multiplier.
//   in_valid/in_ready   operand bundle handshake
//   a, b                packed signed Q operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready result bundle handshake
//   result              packed signed Q products
//   ovf                 per-lane overflow of the current result
//   ovf_sticky/ovf_clr  sticky overflow flag and its synchronous clear
// ---------------------------------------------------------------------------
interface fx_mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   a;
    logic [LANES*WIDTH-1:0]   b;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   result;
    logic [LANES-1:0]         ovf;
    logic                     ovf_sticky;
    logic                     ovf_clr;

    modport master (
        output in_valid, a, b, out_ready, ovf_clr,
        input  in_ready, out_valid, result, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, a, b, out_ready, ovf_clr,
        output in_ready, out_valid, result, ovf, ovf_sticky
    );
endinterface

// File: rtl/fx_round_sat.sv
// ---------------------------------------------------------------------------
// fx_round_sat
// Combinational round / arithmetic shift / saturate for one lane.
//   prod_i    2*WIDTH signed full-precision product
//   result_o  WIDTH-bit Q result
//   ovf_o     scaled value does not fit in WIDTH bits
// Build option FX_MUL_SAT_EN: overflowing lanes clamp to the Q-format
// max/min by sign; otherwise the low WIDTH bits wrap.
// ---------------------------------------------------------------------------
module fx_round_sat
    import fx_pkg::*;
#(
    parameter int WIDTH = FX_DEF_WIDTH,
    parameter int QFRAC = FX_DEF_WIDTH - FX_DEF_QINT,
    parameter int ROUND = FX_RND_TRUNC
) (
    input  logic signed [2*WIDTH-1:0] prod_i,
    output logic        [WIDTH-1:0]   result_o,
    output logic                      ovf_o
);
    // One guard bit above the product so the rounding add cannot overflow.
    localparam int EW = 2*WIDTH + 1;
    localparam logic [EW-1:0] RND_ADD =
        (ROUND == FX_RND_HALF_UP) ? (EW'(1) << (QFRAC - 1)) : '0;

`ifdef FX_MUL_SAT_EN
    localparam logic [FX_MAX_W-1:0] MAX_X = fx_q_max(WIDTH);
    localparam logic [FX_MAX_W-1:0] MIN_X = fx_q_min(WIDTH);
    localparam logic [WIDTH-1:0]    Q_MAX = MAX_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    Q_MIN = MIN_X[WIDTH-1:0];
`endif

    logic signed [EW-1:0]    sum;
    logic signed [EW-1:0]    r;
    logic        [EW-WIDTH:0] hi;

    always_comb begin
        sum = {prod_i[2*WIDTH-1], prod_i} + RND_ADD;
        r   = sum >>> QFRAC;
        // In range only when every bit from the result sign upward agrees.
        hi    = r[EW-1:WIDTH-1];
        ovf_o = !((&hi) || !(|hi));
`ifdef FX_MUL_SAT_EN
        if (ovf_o) begin
            result_o = r[EW-1] ? Q_MIN : Q_MAX;
        end else begin
            result_o = r[WIDTH-1:0];
        end
`else
        result_o = r[WIDTH-1:0];
`endif
    end
endmodule

// File: rtl/fx_mul_pipe.sv
// ---------------------------------------------------------------------------
// fx_mul_pipe
// Multi-lane pipelined signed fixed-point multiplier, valid/ready on both
// sides, LATENCY bundles in flight, order preserved under backpressure.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   fx_mul_pipe_if.slave (operands, results, overflow status)
// Stage 1 holds full products, stages 2..LATENCY-1 delay them, and the
// output registers hold the rounded/shifted/saturated results.
// Build option FX_MUL_SAT_EN selects clamping instead of wrapping on
// overflow (see fx_round_sat).
// ---------------------------------------------------------------------------
module fx_mul_pipe
    import fx_pkg::*;
#(
    parameter int WIDTH   = FX_DEF_WIDTH,
    parameter int QINT    = FX_DEF_QINT,
    parameter int LANES   = FX_DEF_LANES,
    parameter int LATENCY = FX_DEF_LATENCY,
    parameter int ROUND   = FX_RND_TRUNC
) (
    input  logic         clk,
    input  logic         rst,
    fx_mul_pipe_if.slave bus
);
    localparam int QFRAC = WIDTH - QINT;
    localparam int PW    = 2*WIDTH;
    localparam int NSTG  = LATENCY - 1;   // product-carrying stages

    typedef logic signed [PW-1:0] prod_t;

    prod_t                  prod_q [NSTG][LANES];
    prod_t                  prod_d [LANES];
    logic [NSTG-1:0]        vld_q;
    logic                   out_valid_q;
    logic [LANES*WIDTH-1:0] result_q;
    logic [LANES*WIDTH-1:0] result_d;
    logic [LANES-1:0]       ovf_q;
    logic [LANES-1:0]       ovf_d;
    logic                   sticky_q;
    logic                   sticky_d;
    logic                   advance;

    // Whole pipe moves in lockstep; bubbles are held, not squeezed out.
    always_comb begin
        advance = !out_valid_q || bus.out_ready;
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = prod_t'($signed(bus.a[i*WIDTH +: WIDTH]))
                      * prod_t'($signed(bus.b[i*WIDTH +: WIDTH]));
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fx_round_sat #(
            .WIDTH (WIDTH),
            .QFRAC (QFRAC),
            .ROUND (ROUND)
        ) u_round_sat (
            .prod_i   (prod_q[NSTG-1][i]),
            .result_o (result_d[i*WIDTH +: WIDTH]),
            .ovf_o    (ovf_d[i])
        );
    end

    // Set beats clear when both happen on the same edge.
    always_comb begin
        sticky_d = sticky_q;
        if (out_valid_q && bus.out_ready && (|ovf_q)) begin
            sticky_d = 1'b1;
        end else if (bus.ovf_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= '0;
            sticky_q    <= 1'b0;
            for (int s = 0; s < NSTG; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    prod_q[s][l] <= '0;
                end
            end
        end else begin
            sticky_q <= sticky_d;
            if (advance) begin
                vld_q[0] <= bus.in_valid;
                for (int l = 0; l < LANES; l++) begin
                    prod_q[0][l] <= prod_d[l];
                end
                for (int s = 1; s < NSTG; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    for (int l = 0; l < LANES; l++) begin
                        prod_q[s][l] <= prod_q[s-1][l];
                    end
                end
                out_valid_q <= vld_q[NSTG-1];
                result_q    <= result_d;
                // Keep ovf quiet for bubbles so it never flags stale data.
                ovf_q       <= ovf_d & {LANES{vld_q[NSTG-1]}};
            end
        end
    end

    assign bus.in_ready   = advance;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
endmodule
